gcd_controller: RTL and testbench

//  Control FSM for the subtractive (Euclidean) GCD unit; drives the mux selects and load enables of the GCD datapath.

---
 rtl/gcd_pkg.sv | 33 +++
 rtl/gcd_controller_if.sv | 57 +++++
 rtl/gcd_iter_counter.sv | 48 ++++
 rtl/gcd_controller.sv | 179 +++++++++++++++++
 tb/tb_gcd_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
//
// Shared types and defaults for the subtractive GCD controller slice.
//
// Contents:
//   gcd_state_e    controller state encoding (IDLE, LOAD, RUN, DONE, ERR)
//   GCD_WIDTH      default operand width, must match the GCD datapath
//   GCD_MAX_ITER   default number of subtract steps allowed before timeout
//   cnt_width()    width needed to hold an iteration count 0..max_iter
//
// Optional feature macro used elsewhere in this slice: GCD_ZERO_GUARD_EN
// ---------------------------------------------------------------------------
package gcd_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } gcd_state_e;

   localparam int GCD_WIDTH    = 7;
   localparam int GCD_MAX_ITER = 128;

   // The counter has to be able to represent MAX_ITER itself, because the
   // timeout decision is taken when the count has reached exactly that value.
   function automatic int cnt_width(input int max_iter);
      return $clog2(max_iter + 1);
   endfunction

endpackage : gcd_pkg

// File: rtl/gcd_controller_if.sv
// ---------------------------------------------------------------------------
// gcd_controller_if
//
// Bundles every signal between the GCD controller and its surroundings
// (requester handshake, operand buses, datapath flags and datapath controls).
//
// Parameters:
//   WIDTH     operand width
//   MAX_ITER  timeout limit; sizes iter_cnt
//
// Signals:
//   start, op_a, op_b            requester -> controller
//   a_gt_b, a_eq_b, a_lt_b       datapath  -> controller
//   a_sel, b_sel, a_ld, b_ld,
//   output_en                    controller -> datapath
//   busy, done, err, iter_cnt    controller -> requester
//
// Modports:
//   master  the environment (requester plus datapath)
//   slave   the controller
// ---------------------------------------------------------------------------
interface gcd_controller_if
   import gcd_pkg::*;
#(
   parameter int WIDTH    = GCD_WIDTH,
   parameter int MAX_ITER = GCD_MAX_ITER
);

   localparam int CNT_W = cnt_width(MAX_ITER);

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;
   logic             a_sel;
   logic             b_sel;
   logic             a_ld;
   logic             b_ld;
   logic             output_en;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] iter_cnt;

   modport master (
      output start, op_a, op_b, a_gt_b, a_eq_b, a_lt_b,
      input  a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err, iter_cnt
   );

   modport slave (
      input  start, op_a, op_b, a_gt_b, a_eq_b, a_lt_b,
      output a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err, iter_cnt
   );

endinterface : gcd_controller_if

// File: rtl/gcd_iter_counter.sv
// ---------------------------------------------------------------------------
// gcd_iter_counter
//
// Saturating count of subtract steps taken by the GCD controller.
//
// Parameters:
//   MAX_ITER  saturation value (timeout limit)
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active low
//   clear   in   return the count to zero (new computation accepted)
//   inc     in   one subtract step was issued this cycle
//   count   out  current number of steps, held after the run ends
//   at_max  out  count has reached MAX_ITER
// ---------------------------------------------------------------------------
module gcd_iter_counter
   import gcd_pkg::*;
#(
   parameter  int MAX_ITER = GCD_MAX_ITER,
   localparam int CNT_W    = cnt_width(MAX_ITER)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   logic [CNT_W-1:0] count_q;

   assign at_max = (count_q == CNT_W'(MAX_ITER));
   assign count  = count_q;

   // Clear wins over increment; once the limit is reached the count freezes
   // so the reported value never wraps back to a small number.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc && !at_max) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule : gcd_iter_counter

// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
//
// Control FSM for a subtractive (Euclidean) GCD datapath. It loads the two
// operands, then issues one subtraction per cycle (larger minus smaller)
// until the datapath reports equality, at which point the result register
// is captured and done pulses. Inconsistent flags or too many steps abort
// the run with an err pulse and no result capture.
//
// Parameters:
//   WIDTH     operand width, must match the datapath
//   MAX_ITER  subtract steps allowed before timeout (>= 1)
//
// Ports:
//   clk   in     clock, rising edge
//   rst   in     asynchronous reset, active low
//   bus   slave  gcd_controller_if: start/op_a/op_b and datapath flags in;
//                a_sel/b_sel/a_ld/b_ld/output_en, busy/done/err, iter_cnt out
//
// Optional feature (compile-time macro GCD_ZERO_GUARD_EN):
//   when defined, a start with a zero operand goes straight to ERR without
//   touching the datapath; when undefined op_a/op_b are not looked at.
//
// Latency with start sampled in cycle T: LOAD at T+1, first RUN at T+2,
// done at T+3+N where N is the final iter_cnt.
// ---------------------------------------------------------------------------
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int WIDTH    = GCD_WIDTH,
   parameter int MAX_ITER = GCD_MAX_ITER
) (
   input  logic              clk,
   input  logic              rst,
   gcd_controller_if.slave   bus
);

   localparam int CNT_W = cnt_width(MAX_ITER);

   // Reject nonsensical configurations at elaboration time.
   if (WIDTH < 1) begin : g_bad_width
      $error("gcd_controller: WIDTH must be at least 1");
   end
   if (MAX_ITER < 1) begin : g_bad_max_iter
      $error("gcd_controller: MAX_ITER must be at least 1");
   end

   gcd_state_e       state_q;
   gcd_state_e       state_d;

   logic             a_sel;
   logic             b_sel;
   logic             a_ld;
   logic             b_ld;
   logic             output_en;
   logic             busy;
   logic             done;
   logic             err;

   logic             cnt_clear;
   logic             cnt_inc;
   logic             cnt_at_max;
   logic [CNT_W-1:0] cnt;

   logic             flags_valid;
   logic             zero_operand;

   // Exactly one comparison flag must be high; anything else means the
   // datapath is broken or out of step with us, and we refuse to continue.
   assign flags_valid = $onehot({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});

`ifdef GCD_ZERO_GUARD_EN
   // A zero operand would make the subtractive loop spin until timeout
   // (or finish trivially for 0,0), so it is refused before any load.
   assign zero_operand = (bus.op_a == '0) || (bus.op_b == '0);
`else
   assign zero_operand = 1'b0;
`endif

   gcd_iter_counter #(
      .MAX_ITER (MAX_ITER)
   ) u_iter_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .inc    (cnt_inc),
      .count  (cnt),
      .at_max (cnt_at_max)
   );

   // State register. Reset is asynchronous so a mid-run reset drops every
   // control output immediately, without a done or err pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and outputs. All outputs default to 0; each state raises
   // only what it needs. In RUN, bad flags are checked before equality, and
   // equality before the timeout, so a run finishing exactly on the last
   // allowed step still reports done.
   always_comb begin
      state_d   = state_q;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      a_ld      = 1'b0;
      b_ld      = 1'b0;
      output_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_clear = 1'b1;
               state_d   = zero_operand ? ERR : LOAD;
            end
         end

         LOAD: begin
            busy    = 1'b1;
            a_ld    = 1'b1;
            b_ld    = 1'b1;
            state_d = RUN;
         end

         RUN: begin
            busy = 1'b1;
            if (!flags_valid) begin
               state_d = ERR;
            end else if (bus.a_eq_b) begin
               output_en = 1'b1;
               state_d   = DONE;
            end else if (cnt_at_max) begin
               state_d = ERR;
            end else if (bus.a_gt_b) begin
               a_sel   = 1'b1;
               a_ld    = 1'b1;
               cnt_inc = 1'b1;
            end else begin
               b_sel   = 1'b1;
               b_ld    = 1'b1;
               cnt_inc = 1'b1;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         ERR: begin
            err     = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.a_sel     = a_sel;
   assign bus.b_sel     = b_sel;
   assign bus.a_ld      = a_ld;
   assign bus.b_ld      = b_ld;
   assign bus.output_en = output_en;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;
   assign bus.iter_cnt  = cnt;

endmodule : gcd_controller

// File: tb/tb_gcd_controller.sv
// ---------------------------------------------------------------------------
// tb_gcd_controller
//
// Directed bench for gcd_controller. Two controllers are instantiated: one
// with the default MAX_ITER=128 and one with MAX_ITER=4 for the timeout case.
// Each drives a small behavioural model of the GCD datapath (A, B and result
// registers plus comparison flags). Expectations are hand-computed cycle
// numbers relative to the cycle T in which start is high.
// Honours GCD_ZERO_GUARD_EN for the zero-operand expectations.
// ---------------------------------------------------------------------------
module tb_gcd_controller;

   logic clk;
   logic rst;
   logic force_flags;

   int checks;
   int errors;

   gcd_controller_if #(.WIDTH(7), .MAX_ITER(128)) bus  ();
   gcd_controller_if #(.WIDTH(7), .MAX_ITER(4))   bus4 ();

   gcd_controller #(.WIDTH(7), .MAX_ITER(128)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   gcd_controller #(.WIDTH(7), .MAX_ITER(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   // Clock: 10 time units, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model for the default controller.
   logic [6:0] ra, rb, rout;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ra <= '0; rb <= '0; rout <= '0;
      end else begin
         if (bus.a_ld)      ra   <= bus.a_sel ? ra - rb : bus.op_a;
         if (bus.b_ld)      rb   <= bus.b_sel ? rb - ra : bus.op_b;
         if (bus.output_en) rout <= ra;
      end
   end
   assign bus.a_gt_b = force_flags ? 1'b1 : (ra > rb);
   assign bus.a_eq_b = force_flags ? 1'b0 : (ra == rb);
   assign bus.a_lt_b = force_flags ? 1'b1 : (ra < rb);

   // Datapath model for the MAX_ITER=4 controller.
   logic [6:0] ra4, rb4, rout4;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ra4 <= '0; rb4 <= '0; rout4 <= '0;
      end else begin
         if (bus4.a_ld)      ra4   <= bus4.a_sel ? ra4 - rb4 : bus4.op_a;
         if (bus4.b_ld)      rb4   <= bus4.b_sel ? rb4 - ra4 : bus4.op_b;
         if (bus4.output_en) rout4 <= ra4;
      end
   end
   assign bus4.a_gt_b = ra4 > rb4;
   assign bus4.a_eq_b = ra4 == rb4;
   assign bus4.a_lt_b = ra4 < rb4;

   // Per-cycle capture; bit k holds the value seen in cycle T+k.
   logic [199:0] c_a_ld, c_b_ld, c_a_sel, c_b_sel, c_oe, c_busy, c_done, c_err;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise start for the current cycle (cycle T) on the chosen controller.
   task automatic launch(input bit use4, input logic [6:0] a, input logic [6:0] b);
      if (use4) begin
         bus4.op_a = a; bus4.op_b = b; bus4.start = 1'b1;
      end else begin
         bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
      end
   endtask

   // Advance n cycles recording outputs; start is low except at cycle pulse_at.
   task automatic capture(input bit use4, input int n, input int pulse_at);
      c_a_ld = '0; c_b_ld = '0; c_a_sel = '0; c_b_sel = '0;
      c_oe = '0; c_busy = '0; c_done = '0; c_err = '0;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (use4) begin
            c_a_ld[k] = bus4.a_ld;  c_b_ld[k] = bus4.b_ld;
            c_a_sel[k] = bus4.a_sel; c_b_sel[k] = bus4.b_sel;
            c_oe[k] = bus4.output_en; c_busy[k] = bus4.busy;
            c_done[k] = bus4.done;  c_err[k] = bus4.err;
            bus4.start = (k == pulse_at);
         end else begin
            c_a_ld[k] = bus.a_ld;  c_b_ld[k] = bus.b_ld;
            c_a_sel[k] = bus.a_sel; c_b_sel[k] = bus.b_sel;
            c_oe[k] = bus.output_en; c_busy[k] = bus.busy;
            c_done[k] = bus.done;  c_err[k] = bus.err;
            bus.start = (k == pulse_at);
         end
      end
   endtask

   function automatic int first_set(input logic [199:0] v);
      for (int i = 0; i < 200; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.a_sel, bus.b_sel, bus.a_ld, bus.b_ld, bus.output_en,
           bus.busy, bus.done, bus.err} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b, expected 00000000",
                  {bus.a_sel, bus.b_sel, bus.a_ld, bus.b_ld, bus.output_en,
                   bus.busy, bus.done, bus.err});
      end
      checks++;
      if (bus.iter_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_iter_cnt: got %0d, expected 0", bus.iter_cnt);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({bus4.busy, bus4.done, bus4.err, bus4.a_ld, bus4.b_ld} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_dut4: got %b, expected 00000",
                  {bus4.busy, bus4.done, bus4.err, bus4.a_ld, bus4.b_ld});
      end
   endtask

   // (12,18): B=18-12=6 at T+2, A=12-6=6 at T+3, equal at T+4, done at T+5.
   task automatic test_basic();
      launch(1'b0, 7'd12, 7'd18);
      capture(1'b0, 8, 0);
      checks++;
      if ({c_busy[1], c_a_ld[1], c_b_ld[1], c_a_sel[1], c_b_sel[1]} !== 5'b11100) begin
         errors++;
         $display("[TB] FAIL basic_load: got %b, expected 11100",
                  {c_busy[1], c_a_ld[1], c_b_ld[1], c_a_sel[1], c_b_sel[1]});
      end
      checks++;
      if ({c_a_ld[2], c_b_ld[2], c_b_sel[2]} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL basic_b_step: got %b, expected 011",
                  {c_a_ld[2], c_b_ld[2], c_b_sel[2]});
      end
      checks++;
      if ({c_a_ld[3], c_a_sel[3], c_b_ld[3]} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL basic_a_step: got %b, expected 110",
                  {c_a_ld[3], c_a_sel[3], c_b_ld[3]});
      end
      checks++;
      if (first_set(c_oe) !== 4) begin
         errors++;
         $display("[TB] FAIL basic_output_en_cycle: got %0d, expected 4", first_set(c_oe));
      end
      checks++;
      if (first_set(c_done) !== 5 || $countones(c_done) !== 1) begin
         errors++;
         $display("[TB] FAIL basic_done: got cycle %0d count %0d, expected cycle 5 count 1",
                  first_set(c_done), $countones(c_done));
      end
      checks++;
      if (rout !== 7'd6 || bus.iter_cnt !== 8'd2) begin
         errors++;
         $display("[TB] FAIL basic_result: got out=%0d iter=%0d, expected out=6 iter=2",
                  rout, bus.iter_cnt);
      end
   endtask

   task automatic test_equal();
      launch(1'b0, 7'd7, 7'd7);
      capture(1'b0, 6, 0);
      checks++;
      if (first_set(c_oe) !== 2 || first_set(c_done) !== 3) begin
         errors++;
         $display("[TB] FAIL equal_timing: got oe=%0d done=%0d, expected oe=2 done=3",
                  first_set(c_oe), first_set(c_done));
      end
      checks++;
      if ({c_a_ld[2], c_b_ld[2]} !== 2'b00 || rout !== 7'd7 || bus.iter_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL equal_result: got loads=%b out=%0d iter=%0d, expected loads=00 out=7 iter=0",
                  {c_a_ld[2], c_b_ld[2]}, rout, bus.iter_cnt);
      end
   endtask

   task automatic test_timeout();
      // (1,127): B walks down by 1 for 126 steps; done at T+3+126.
      launch(1'b0, 7'd1, 7'd127);
      capture(1'b0, 135, 0);
      checks++;
      if (first_set(c_done) !== 129 || rout !== 7'd1 || bus.iter_cnt !== 8'd126) begin
         errors++;
         $display("[TB] FAIL long_run: got done=%0d out=%0d iter=%0d, expected done=129 out=1 iter=126",
                  first_set(c_done), rout, bus.iter_cnt);
      end
      // Give dut4 a known result (3,6 -> 3) so the abort can be seen to keep it.
      launch(1'b1, 7'd3, 7'd6);
      capture(1'b1, 8, 0);
      checks++;
      if (first_set(c_done) !== 4 || rout4 !== 7'd3) begin
         errors++;
         $display("[TB] FAIL small_run: got done=%0d out=%0d, expected done=4 out=3",
                  first_set(c_done), rout4);
      end
      // (1,10) with MAX_ITER=4: 4 steps at T+2..T+5, timeout at T+6, err at T+7.
      launch(1'b1, 7'd1, 7'd10);
      capture(1'b1, 10, 0);
      checks++;
      if (first_set(c_err) !== 7 || bus4.iter_cnt !== 3'd4) begin
         errors++;
         $display("[TB] FAIL timeout_err: got err=%0d iter=%0d, expected err=7 iter=4",
                  first_set(c_err), bus4.iter_cnt);
      end
      checks++;
      if (c_oe !== '0 || c_done !== '0 || rout4 !== 7'd3) begin
         errors++;
         $display("[TB] FAIL timeout_no_result: got oe=%0d done=%0d out=%0d, expected 0 0 3",
                  $countones(c_oe), $countones(c_done), rout4);
      end
   endtask

   task automatic test_zero();
      launch(1'b0, 7'd0, 7'd9);
      capture(1'b0, 135, 0);
`ifdef GCD_ZERO_GUARD_EN
      checks++;
      if (first_set(c_err) !== 1 || c_a_ld !== '0 || c_b_ld !== '0 || c_busy !== '0) begin
         errors++;
         $display("[TB] FAIL zero_guard: got err=%0d loads=%0d busy=%0d, expected err=1 loads=0 busy=0",
                  first_set(c_err), $countones(c_a_ld | c_b_ld), $countones(c_busy));
      end
      launch(1'b0, 7'd0, 7'd0);
      capture(1'b0, 6, 0);
      checks++;
      if (first_set(c_err) !== 1 || c_done !== '0) begin
         errors++;
         $display("[TB] FAIL zero_guard_both: got err=%0d done=%0d, expected err=1 done=0",
                  first_set(c_err), $countones(c_done));
      end
`else
      // B stays 9 (9-0) forever: 128 steps at T+2..T+129, err at T+131.
      checks++;
      if (first_set(c_err) !== 131 || bus.iter_cnt !== 8'd128 || c_done !== '0) begin
         errors++;
         $display("[TB] FAIL zero_timeout: got err=%0d iter=%0d done=%0d, expected err=131 iter=128 done=0",
                  first_set(c_err), bus.iter_cnt, $countones(c_done));
      end
      launch(1'b0, 7'd0, 7'd0);
      capture(1'b0, 6, 0);
      checks++;
      if (first_set(c_done) !== 3 || rout !== 7'd0) begin
         errors++;
         $display("[TB] FAIL zero_both: got done=%0d out=%0d, expected done=3 out=0",
                  first_set(c_done), rout);
      end
`endif
   endtask

   task automatic test_protocol();
      // Contradictory flags in the first RUN cycle: no loads, err next cycle.
      launch(1'b0, 7'd12, 7'd18);
      tick(); bus.start = 1'b0;
      tick();
      force_flags = 1'b1;
      #1;
      checks++;
      if ({bus.a_ld, bus.b_ld, bus.output_en} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL bad_flags_no_load: got %b, expected 000",
                  {bus.a_ld, bus.b_ld, bus.output_en});
      end
      tick();
      force_flags = 1'b0;
      checks++;
      if ({bus.err, bus.busy, bus.done} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL bad_flags_err: got %b, expected 100",
                  {bus.err, bus.busy, bus.done});
      end
      tick();
      // Start pulsed at T+2 while busy must not queue a second run.
      launch(1'b0, 7'd12, 7'd18);
      capture(1'b0, 14, 2);
      checks++;
      if (first_set(c_done) !== 5 || $countones(c_done) !== 1 || c_busy[14:6] !== '0) begin
         errors++;
         $display("[TB] FAIL busy_start_ignored: got done=%0d count=%0d late_busy=%0d, expected 5 1 0",
                  first_set(c_done), $countones(c_done), $countones(c_busy[14:6]));
      end
   endtask

   task automatic test_reset_mid_run();
      launch(1'b0, 7'd100, 7'd35);
      tick(); bus.start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.a_sel, bus.b_sel, bus.a_ld, bus.b_ld, bus.output_en,
           bus.busy, bus.done, bus.err} !== 8'h00 || bus.iter_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run: got %b iter=%0d, expected 00000000 iter=0",
                  {bus.a_sel, bus.b_sel, bus.a_ld, bus.b_ld, bus.output_en,
                   bus.busy, bus.done, bus.err}, bus.iter_cnt);
      end
      tick();
      rst = 1'b1;
      tick();
      // (100,35): A 65, A 30, B 5, A 25, 20, 15, 10, 5 -> 8 steps, done at T+11.
      launch(1'b0, 7'd100, 7'd35);
      capture(1'b0, 15, 0);
      checks++;
      if (first_set(c_done) !== 11 || rout !== 7'd5 || bus.iter_cnt !== 8'd8) begin
         errors++;
         $display("[TB] FAIL after_reset_run: got done=%0d out=%0d iter=%0d, expected done=11 out=5 iter=8",
                  first_set(c_done), rout, bus.iter_cnt);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      force_flags = 1'b0;
      bus.start   = 1'b0;
      bus.op_a    = '0;
      bus.op_b    = '0;
      bus4.start  = 1'b0;
      bus4.op_a   = '0;
      bus4.op_b   = '0;
      $display("[TB] gcd_controller directed test starting");
      test_reset();
      test_basic();
      test_equal();
      test_timeout();
      test_zero();
      test_protocol();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule : tb_gcd_controller
